sfence_flush_ctrl: RTL and testbench
====================================

Name: sfence_flush_ctrl

Overview:
- Sequences an SFENCE.VMA TLB invalidation as a multi-cycle operation instead of a single-cycle flush pulse.
- Accepts the sfence request from the memory stage and stalls the pipeline.
- Waits for outstanding memory/page-walk activity to drain, then walks every TLB entry index with an invalidate command under a valid/ready handshake.
- When the walk completes, pulses a pipeline flush so fetch restarts with fresh translations.

Parameters:
- TLB_ENTRIES, 16, number of TLB entries to walk; power of two, at least 2.
- IDX_W, $clog2(TLB_ENTRIES), width of the entry index.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- sfence_i  in  1  sfence request from memory stage; one-cycle pulse.
- sfence_type_i  in  1  0 = global flush (all entries); 1 = selective flush (TLB matches vaddr/asid).
- rs1_data_i  in  32  flush virtual address.
- rs2_data_i  in  32  flush ASID.
- mem_busy_i  in  1  outstanding D-memory or page-walk transaction in flight.
- tlb_inv_valid_o  out  1  invalidate command valid.
- tlb_inv_ready_i  in  1  TLB accepts the command.
- tlb_inv_idx_o  out  IDX_W  entry index being invalidated.
- tlb_inv_type_o  out  1  latched sfence_type.
- tlb_inv_vaddr_o  out  32  latched rs1_data.
- tlb_inv_asid_o  out  32  latched rs2_data.
- stall_o  out  1  stall PC and all pipeline registers.
- flush_o  out  1  one-cycle flush of fetch/decode/execute.
- busy_o  out  1  state != IDLE.
- sfence_cnt_o  out  32  perf counter (see Optional Feature).
- stall_cyc_cnt_o  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset (rst_ni low, asynchronous): state = IDLE; idx = 0; latched type/vaddr/asid = 0; counters = 0. All outputs 0. If reset asserts mid-walk, the walk is abandoned and no flush_o is issued.
- States: IDLE, DRAIN, WALK, DONE.
- IDLE:
  - On sfence_i: latch type/vaddr/asid and set idx = 0.
  - Next state is WALK if mem_busy_i = 0 in that same cycle, otherwise DRAIN.
- DRAIN: hold until mem_busy_i = 0, then go to WALK.
- WALK:
  - tlb_inv_valid_o = 1.
  - On valid & ready: if idx == TLB_ENTRIES-1, go to DONE; otherwise idx increments by 1.
  - With ready low, idx and all tlb_inv_* outputs hold stable; valid is never withdrawn.
  - idx never wraps; the walk always ends at TLB_ENTRIES-1.
- DONE: flush_o = 1 for exactly one cycle, then go to IDLE.
- stall_o = sfence_i | (state ∈ {DRAIN, WALK}). This is combinational on sfence_i, so the accepting cycle is already stalled. stall_o is 0 in DONE, in the same cycle as flush_o.
- busy_o = (state != IDLE).
- sfence_i outside IDLE is ignored (pipeline is stalled, so this is illegal): no relatch, no state change.
- sfence_i in the DONE cycle is also ignored.
- Latency with mem_busy_i = 0 and ready always 1:
  - accept at cycle 0;
  - tlb_inv_valid_o high cycles 1..TLB_ENTRIES;
  - flush_o at cycle TLB_ENTRIES+1;
  - total stall cycles = TLB_ENTRIES+1.
- tlb_inv_type_o, tlb_inv_vaddr_o and tlb_inv_asid_o are constant from the cycle after acceptance until return to IDLE.

Optional Feature:
- Macro: SFENCE_PERF_CNT_EN.
- Defined:
  - sfence_cnt_o increments once per accepted sfence.
  - stall_cyc_cnt_o increments every cycle stall_o = 1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- TLB_ENTRIES=16, mem_busy_i=0, ready=1, sfence_i with type=0 at cycle 0 → stall_o high cycles 0..16; idx 0..15 on cycles 1..16; flush_o only at cycle 17.
- mem_busy_i held 1 for 5 cycles after acceptance → state DRAIN for 5 cycles, tlb_inv_valid_o=0 throughout; walk starts the cycle after mem_busy_i falls; flush_o at accept+5+17.
- ready toggles 1,0,0,1 repeatedly during the walk, type=1, vaddr=0x8000_1000, asid=0x3 → idx advances only on accepted beats; vaddr/asid/type held; all 16 indices issued exactly once.
- Second sfence_i pulsed at idx=7 during WALK → ignored; latched vaddr unchanged; exactly one flush_o.
- rst_ni asserted at idx=9 → all outputs 0 immediately; after release, a fresh sfence walks from idx 0.
- With SFENCE_PERF_CNT_EN, two back-to-back sfences, no drain, ready=1 → sfence_cnt_o=2, stall_cyc_cnt_o=34.

Source files
------------

// File: rtl/sfence_flush_ctrl.sv
// SFENCE.VMA sequencer: stalls the pipeline, drains memory traffic, walks every TLB index
// with an invalidate command, then pulses a flush. Optional perf counters: SFENCE_PERF_CNT_EN.
module sfence_flush_ctrl #(
    parameter int unsigned TLB_ENTRIES = 16,
    parameter int unsigned IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sfence_i,
    input  logic             sfence_type_i,
    input  logic [31:0]      rs1_data_i,
    input  logic [31:0]      rs2_data_i,
    input  logic             mem_busy_i,
    output logic             tlb_inv_valid_o,
    input  logic             tlb_inv_ready_i,
    output logic [IDX_W-1:0] tlb_inv_idx_o,
    output logic             tlb_inv_type_o,
    output logic [31:0]      tlb_inv_vaddr_o,
    output logic [31:0]      tlb_inv_asid_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic             busy_o,
    output logic [31:0]      sfence_cnt_o,
    output logic [31:0]      stall_cyc_cnt_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StWalk  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(TLB_ENTRIES - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             type_q, type_d;
    logic [31:0]      vaddr_q, vaddr_d;
    logic [31:0]      asid_q, asid_d;
    logic             accept;

    // Requests are only honoured from idle; elsewhere the pipeline is already stalled.
    assign accept = sfence_i && (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        type_d  = type_q;
        vaddr_d = vaddr_q;
        asid_d  = asid_q;
        unique case (state_q)
            StIdle: begin
                if (sfence_i) begin
                    type_d  = sfence_type_i;
                    vaddr_d = rs1_data_i;
                    asid_d  = rs2_data_i;
                    idx_d   = '0;
                    state_d = mem_busy_i ? StDrain : StWalk;
                end
            end
            StDrain: begin
                if (!mem_busy_i) begin
                    state_d = StWalk;
                end
            end
            StWalk: begin
                if (tlb_inv_ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            type_q  <= 1'b0;
            vaddr_q <= '0;
            asid_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            type_q  <= type_d;
            vaddr_q <= vaddr_d;
            asid_q  <= asid_d;
        end
    end

    assign tlb_inv_valid_o = (state_q == StWalk);
    assign tlb_inv_idx_o   = idx_q;
    assign tlb_inv_type_o  = type_q;
    assign tlb_inv_vaddr_o = vaddr_q;
    assign tlb_inv_asid_o  = asid_q;
    assign stall_o         = accept || (state_q == StDrain) || (state_q == StWalk);
    assign flush_o         = (state_q == StDone);
    assign busy_o          = (state_q != StIdle);

`ifdef SFENCE_PERF_CNT_EN
    logic [31:0] sfence_cnt_q, stall_cyc_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sfence_cnt_q    <= '0;
            stall_cyc_cnt_q <= '0;
        end else begin
            if (accept) begin
                sfence_cnt_q <= sfence_cnt_q + 32'd1;
            end
            if (stall_o) begin
                stall_cyc_cnt_q <= stall_cyc_cnt_q + 32'd1;
            end
        end
    end

    assign sfence_cnt_o    = sfence_cnt_q;
    assign stall_cyc_cnt_o = stall_cyc_cnt_q;
`else
    assign sfence_cnt_o    = '0;
    assign stall_cyc_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sfence_flush_ctrl.sv
// Scoreboard bench for sfence_flush_ctrl: expected invalidate beats are queued when an
// sfence is issued and popped on each accepted handshake.
module tb_sfence_flush_ctrl;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        sfence_i;
    logic        sfence_type_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        mem_busy_i;
    logic        tlb_inv_valid_o;
    logic        tlb_inv_ready_i;
    logic [3:0]  tlb_inv_idx_o;
    logic        tlb_inv_type_o;
    logic [31:0] tlb_inv_vaddr_o;
    logic [31:0] tlb_inv_asid_o;
    logic        stall_o;
    logic        flush_o;
    logic        busy_o;
    logic [31:0] sfence_cnt_o;
    logic [31:0] stall_cyc_cnt_o;

    always #5 clk = ~clk;

    sfence_flush_ctrl #(
        .TLB_ENTRIES(N)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .sfence_i       (sfence_i),
        .sfence_type_i  (sfence_type_i),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .mem_busy_i     (mem_busy_i),
        .tlb_inv_valid_o(tlb_inv_valid_o),
        .tlb_inv_ready_i(tlb_inv_ready_i),
        .tlb_inv_idx_o  (tlb_inv_idx_o),
        .tlb_inv_type_o (tlb_inv_type_o),
        .tlb_inv_vaddr_o(tlb_inv_vaddr_o),
        .tlb_inv_asid_o (tlb_inv_asid_o),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .busy_o         (busy_o),
        .sfence_cnt_o   (sfence_cnt_o),
        .stall_cyc_cnt_o(stall_cyc_cnt_o)
    );

    typedef struct packed {
        logic [3:0]  idx;
        logic        typ;
        logic [31:0] vaddr;
        logic [31:0] asid;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc, beats, flushes, stall_cycles, first_valid, flush_cyc;
    int          ready_mode;
    logic        hold_pend;
    logic [3:0]  hold_idx;
    logic [31:0] hold_vaddr;
    logic        aborted;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        cyc          = 0;
        beats        = 0;
        flushes      = 0;
        stall_cycles = 0;
        first_valid  = -1;
        flush_cyc    = -1;
        hold_pend    = 1'b0;
    endtask

    task automatic monitor();
        beat_t e;
        if (hold_pend) begin
            check_eq("hold_valid", 32'(tlb_inv_valid_o), 32'd1);
            check_eq("hold_idx", 32'(tlb_inv_idx_o), 32'(hold_idx));
            check_eq("hold_vaddr", tlb_inv_vaddr_o, hold_vaddr);
        end
        hold_pend  = tlb_inv_valid_o && !tlb_inv_ready_i;
        hold_idx   = tlb_inv_idx_o;
        hold_vaddr = tlb_inv_vaddr_o;
        if (tlb_inv_valid_o && first_valid < 0) first_valid = cyc;
        if (tlb_inv_valid_o && tlb_inv_ready_i) begin
            beats++;
            if (exp_q.size() == 0) begin
                check_eq("beat_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("beat_idx", 32'(tlb_inv_idx_o), 32'(e.idx));
                check_eq("beat_type", 32'(tlb_inv_type_o), 32'(e.typ));
                check_eq("beat_vaddr", tlb_inv_vaddr_o, e.vaddr);
                check_eq("beat_asid", tlb_inv_asid_o, e.asid);
            end
        end
        if (flush_o) begin
            flushes++;
            flush_cyc = cyc;
            check_eq("stall_in_done", 32'(stall_o), 32'd0);
        end
        if (stall_o) stall_cycles++;
    endtask

    // Inputs are set at a negedge; outputs are sampled 1ns later, before the next posedge.
    task automatic step();
        #1;
        monitor();
        @(negedge clk);
        cyc++;
    endtask

    task automatic issue(input logic typ, input logic [31:0] va, input logic [31:0] as,
                         input logic busy);
        beat_t b;
        sfence_i      = 1'b1;
        sfence_type_i = typ;
        rs1_data_i    = va;
        rs2_data_i    = as;
        mem_busy_i    = busy;
        tlb_inv_ready_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            b.idx   = 4'(i);
            b.typ   = typ;
            b.vaddr = va;
            b.asid  = as;
            exp_q.push_back(b);
        end
        step();
        sfence_i = 1'b0;
        // Scramble the sources so a missing latch shows up in the beat checks.
        rs1_data_i    = $urandom;
        rs2_data_i    = $urandom;
        sfence_type_i = ~typ;
    endtask

    task automatic run_walk(input int budget, input int busy_until, input int inject_idx,
                            input int abort_idx, output logic abort_hit);
        logic injected;
        injected  = 1'b0;
        abort_hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            mem_busy_i      = (cyc < busy_until);
            tlb_inv_ready_i = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (abort_idx >= 0 && tlb_inv_valid_o && tlb_inv_idx_o == 4'(abort_idx)) begin
                abort_hit = 1'b1;
                return;
            end
            if (inject_idx >= 0 && !injected && tlb_inv_valid_o &&
                tlb_inv_idx_o == 4'(inject_idx)) begin
                sfence_i   = 1'b1;
                rs1_data_i = 32'hDEAD_BEEF;
                injected   = 1'b1;
            end
            step();
            sfence_i = 1'b0;
            if (!busy_o) return;
        end
        check_eq("walk_timeout", 32'd1, 32'd0);
    endtask

    task automatic end_checks(input string tag);
        check_eq({tag, "_beats"}, 32'(beats), 32'(N));
        check_eq({tag, "_flushes"}, 32'(flushes), 32'd1);
        check_eq({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_ni          = 1'b0;
        sfence_i        = 1'b0;
        sfence_type_i   = 1'b0;
        rs1_data_i      = '0;
        rs2_data_i      = '0;
        mem_busy_i      = 1'b0;
        tlb_inv_ready_i = 1'b1;
        ready_mode      = 0;
        clear_stats();
        #12;
        check_eq("rst_valid", 32'(tlb_inv_valid_o), 32'd0);
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        check_eq("rst_flush", 32'(flush_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_idx", 32'(tlb_inv_idx_o), 32'd0);
        check_eq("rst_vaddr", tlb_inv_vaddr_o, 32'd0);
        check_eq("rst_cnt", sfence_cnt_o, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        step();

        // Global flush, no drain, ready always high.
        clear_stats();
        issue(1'b0, 32'h0000_4000, 32'h0000_0001, 1'b0);
        run_walk(100, 0, -1, -1, aborted);
        check_eq("t1_first_valid", 32'(first_valid), 32'd1);
        check_eq("t1_flush_cyc", 32'(flush_cyc), 32'd17);
        check_eq("t1_stall_cycles", 32'(stall_cycles), 32'd17);
        end_checks("t1");

        // Memory busy for the accept cycle plus four more.
        clear_stats();
        issue(1'b0, 32'h1234_5000, 32'h0000_0007, 1'b1);
        run_walk(100, 5, -1, -1, aborted);
        check_eq("t2_first_valid", 32'(first_valid), 32'd6);
        check_eq("t2_flush_cyc", 32'(flush_cyc), 32'd22);
        check_eq("t2_stall_cycles", 32'(stall_cycles), 32'd22);
        end_checks("t2");

        // Ready toggling 1,0,0,1 with a selective flush.
        clear_stats();
        ready_mode = 1;
        issue(1'b1, 32'h8000_1000, 32'h0000_0003, 1'b0);
        run_walk(200, 0, -1, -1, aborted);
        end_checks("t3");
        ready_mode = 0;

        // Illegal second sfence mid-walk is ignored.
        clear_stats();
        issue(1'b0, 32'hCAFE_0000, 32'h0000_0011, 1'b0);
        run_walk(100, 0, 7, -1, aborted);
        end_checks("t4");
        step();
        check_eq("t4_idle_after", 32'(busy_o), 32'd0);

        // Reset mid-walk abandons it without a flush.
        clear_stats();
        issue(1'b1, 32'h5555_0000, 32'h0000_0022, 1'b0);
        run_walk(100, 0, -1, 9, aborted);
        check_eq("t5_abort_reached", 32'(aborted), 32'd1);
        rst_ni = 1'b0;
        #1;
        check_eq("t5_rst_valid", 32'(tlb_inv_valid_o), 32'd0);
        check_eq("t5_rst_stall", 32'(stall_o), 32'd0);
        check_eq("t5_rst_busy", 32'(busy_o), 32'd0);
        check_eq("t5_rst_idx", 32'(tlb_inv_idx_o), 32'd0);
        check_eq("t5_rst_vaddr", tlb_inv_vaddr_o, 32'd0);
        check_eq("t5_rst_asid", tlb_inv_asid_o, 32'd0);
        check_eq("t5_rst_type", 32'(tlb_inv_type_o), 32'd0);
        check_eq("t5_no_flush", 32'(flushes), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        clear_stats();
        issue(1'b0, 32'h0BAD_F000, 32'h0000_0005, 1'b0);
        run_walk(100, 0, -1, -1, aborted);
        end_checks("t5_fresh");

        // Counters from a clean reset across two back-to-back sfences.
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        clear_stats();
        issue(1'b0, 32'h0000_1000, 32'h0000_0001, 1'b0);
        run_walk(100, 0, -1, -1, aborted);
        issue(1'b0, 32'h0000_2000, 32'h0000_0002, 1'b0);
        run_walk(100, 0, -1, -1, aborted);
        check_eq("t6_stall_cycles", 32'(stall_cycles), 32'd34);
        check_eq("t6_flushes", 32'(flushes), 32'd2);
`ifdef SFENCE_PERF_CNT_EN
        check_eq("t6_sfence_cnt", sfence_cnt_o, 32'd2);
        check_eq("t6_stall_cyc_cnt", stall_cyc_cnt_o, 32'd34);
`else
        check_eq("t6_sfence_cnt_tied", sfence_cnt_o, 32'd0);
        check_eq("t6_stall_cyc_cnt_tied", stall_cyc_cnt_o, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
